// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise, deglitch and decode Gray-code phase steps for an up/down counter.
// Build option QSD_ERR_CNT_EN adds a saturating illegal-transition counter on err_cnt.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic [1:0] phase,
    output logic [7:0] err_cnt
);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

    // Channel index 1 is A, 0 is B, so phase reads as {a,b}.
    logic [SYNC_STAGES-1:0] sync_p0 [2];
    logic [1:0]             sab;
    logic [CNT_W-1:0]       filt_cnt [2];
    logic [1:0]             prev_phase;
    logic                   primed;
    logic [1:0]             prime_ref;
    logic [CNT_W-1:0]       prime_cnt;
    logic                   is_up, is_down, is_bad;

    assign sab = {sync_p0[1][SYNC_STAGES-1], sync_p0[0][SYNC_STAGES-1]};

    // Position of a phase along the up-counting Gray cycle 00,10,11,01.
    function automatic logic [1:0] gray_pos(input logic [1:0] p);
        case (p)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    always_comb begin
        logic [1:0] delta;
        delta   = gray_pos(phase) - gray_pos(prev_phase);
        is_up   = primed && (delta == 2'd1);
        is_down = primed && (delta == 2'd3);
        is_bad  = primed && (delta == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_p0[i]  <= '0;
                filt_cnt[i] <= '0;
            end
            phase      <= 2'b00;
            prev_phase <= 2'b00;
            primed     <= 1'b0;
            prime_ref  <= 2'b00;
            prime_cnt  <= '0;
            step       <= 1'b0;
            err        <= 1'b0;
            dir        <= 1'b1;
        end else begin
            sync_p0[1] <= {sync_p0[1][SYNC_STAGES-2:0], a_in};
            sync_p0[0] <= {sync_p0[0][SYNC_STAGES-2:0], b_in};

            // Decode stage: compare the phase against its value one cycle earlier.
            prev_phase <= phase;
            step       <= is_up || is_down;
            err        <= is_bad;
            if (is_up || is_down)
                dir <= is_up;

            if (primed) begin
                for (int i = 0; i < 2; i++) begin
                    if (sab[i] == phase[i]) begin
                        filt_cnt[i] <= '0;
                    end else if (filt_cnt[i] == FILT_LAST) begin
                        phase[i]    <= sab[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + 1'b1;
                    end
                end
            end else begin
                // Priming: load both channels silently once they have settled together.
                if (sab != prime_ref) begin
                    prime_ref <= sab;
                    prime_cnt <= '0;
                end else if (prime_cnt == FILT_LAST) begin
                    phase      <= prime_ref;
                    prev_phase <= prime_ref;
                    primed     <= 1'b1;
                    prime_cnt  <= '0;
                end else begin
                    prime_cnt <= prime_cnt + 1'b1;
                end
            end
        end
    end

`ifdef QSD_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= 8'h00;
        else if (err && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'h01;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: reset, up/down stepping, glitch rejection, illegal moves, reset mid-step.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       step, dir, err;
    logic [1:0] phase;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef QSD_ERR_CNT_EN
    localparam logic [7:0] EXP_CNT1 = 8'h01;
    localparam logic [7:0] EXP_CNTF = 8'hFF;
`else
    localparam logic [7:0] EXP_CNT1 = 8'h00;
    localparam logic [7:0] EXP_CNTF = 8'h00;
`endif

    quad_step_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .phase   (phase),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a new {a,b} and check the step/err pulse lands exactly on the 6th edge.
    task automatic move(input logic a, input logic b, input logic es, input logic ee,
                        input logic ed, input string tag);
        @(negedge clk);
        a_in = a;
        b_in = b;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) begin
                chk({tag, " step"}, 8'(step), 8'(es));
                chk({tag, " err"}, 8'(err), 8'(ee));
                chk({tag, " dir"}, 8'(dir), 8'(ed));
            end else if (k == 5 || k == 7) begin
                chk({tag, " step early/late"}, 8'(step), 8'h00);
                chk({tag, " err early/late"}, 8'(err), 8'h00);
            end
        end
    endtask

    task automatic window(input int n, output int ns, output int ne);
        ns = 0;
        ne = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (step) ns++;
            if (err) ne++;
        end
    endtask

    initial begin
        int ns, ne;

        // Reset with both inputs low
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset step", 8'(step), 8'h00);
        chk("reset err", 8'(err), 8'h00);
        chk("reset dir", 8'(dir), 8'h01);
        chk("reset phase", 8'(phase), 8'h00);
        chk("reset err_cnt", err_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        window(12, ns, ne);
        chk("prime steps", 8'(ns), 8'h00);
        chk("prime errs", 8'(ne), 8'h00);
        chk("prime phase", 8'(phase), 8'h00);

        // Up sequence
        move(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "up 00-10");
        move(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "up 10-11");
        move(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "up 11-01");
        move(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "up 01-00");
        chk("up end phase", 8'(phase), 8'h00);

        // Down sequence, then a single up move and back down
        move(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "dn 00-01");
        move(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "dn 01-11");
        move(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "dn 11-10");
        move(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dn 10-00");
        chk("dn end phase", 8'(phase), 8'h00);
        move(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "up 00-10 again");
        chk("up again phase", 8'(phase), 8'h02);
        move(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dn 10-00 again");

        // Glitch of 2 cycles is rejected
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        window(14, ns, ne);
        chk("glitch2 steps", 8'(ns), 8'h00);
        chk("glitch2 errs", 8'(ne), 8'h00);
        chk("glitch2 phase", 8'(phase), 8'h00);

        // Pulse of 3 cycles passes: up then down
        @(negedge clk);
        a_in = 1'b1;
        repeat (3) @(negedge clk);
        a_in = 1'b0;
        window(20, ns, ne);
        chk("pulse3 steps", 8'(ns), 8'h02);
        chk("pulse3 errs", 8'(ne), 8'h00);
        chk("pulse3 phase", 8'(phase), 8'h00);
        chk("pulse3 dir", 8'(dir), 8'h00);

        // Illegal two-bit transition
        move(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "illegal 00-11");
        chk("illegal phase", 8'(phase), 8'h03);
        chk("illegal err_cnt", err_cnt, EXP_CNT1);
        move(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "illegal 11-00");
        for (int i = 0; i < 298; i++) begin
            @(negedge clk);
            a_in = ~a_in;
            b_in = ~b_in;
            repeat (7) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("err_cnt saturate", err_cnt, EXP_CNTF);
        chk("after illegals phase", 8'(phase), 8'h00);
        chk("after illegals dir", 8'(dir), 8'h00);

        // Reset on the edge a step is due, release with inputs at 11
        @(negedge clk);
        a_in = 1'b1;
        b_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        b_in = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst step", 8'(step), 8'h00);
        chk("midrst phase", 8'(phase), 8'h00);
        chk("midrst dir", 8'(dir), 8'h01);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        window(15, ns, ne);
        chk("reprime steps", 8'(ns), 8'h00);
        chk("reprime errs", 8'(ne), 8'h00);
        chk("reprime phase", 8'(phase), 8'h03);
        chk("reprime dir", 8'(dir), 8'h01);
        chk("reprime err_cnt", err_cnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
